// File: rtl/div_nr_param_pkg.sv
// Shared types and helpers for the radix-2 non-restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } div_state_t;

  localparam int MAX_W = 64;
  localparam logic [MAX_W-1:0] DIV_ZERO_Q = '1;

  // Two's-complement magnitude; MIN maps to 2^(W-1) once truncated to W bits.
  function automatic logic [MAX_W-1:0] abs_mag(input logic [MAX_W-1:0] x, input logic sgn);
    return sgn ? (~x + 64'd1) : x;
  endfunction

endpackage

// File: rtl/div_nr_param_if.sv
// Start/busy/over handshake and operand/result bus of the divider.
interface div_nr_param_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             busy;
  logic             over;
  logic             div_zero;

  modport master (
    output start, is_signed, dividend, divisor,
    input  q, r, busy, over, div_zero
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output q, r, busy, over, div_zero
  );
endinterface

// File: rtl/div_nr_param_step.sv
// One combinational non-restoring iteration on a WIDTH+1-bit signed partial remainder.
module div_nr_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_next,
  output logic             q_bit
);
  logic [WIDTH:0] shifted;

  // Intermediate wrap is harmless: the true result always lies in [-d, d).
  always_comb begin
    shifted = {rem[WIDTH-1:0], q_msb};
    if (rem[WIDTH]) rem_next = shifted + {1'b0, divisor};
    else            rem_next = shifted - {1'b0, divisor};
    q_bit = ~rem_next[WIDTH];
  end
endmodule

// File: rtl/div_nr_param.sv
// Multi-cycle signed/unsigned integer divider with start/busy/over handshake.
// state | meaning
// IDLE  | waiting for start; results held
// RUN   | one quotient bit per clock (one dummy cycle for divide-by-zero)
// FIX   | remainder correction, sign fix-up, results registered, over pulsed
module div_nr_param
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic           clock,
  input logic           reset,
  div_nr_param_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic             sgn_quo_q, sgn_quo_d, sgn_rem_q, sgn_rem_d;
  logic             zflag_q, zflag_d;
  logic [WIDTH-1:0] q_q, q_d, r_q, r_d;
  logic             dz_q, dz_d, busy_q, busy_d, over_q, over_d;

  logic [WIDTH:0]   step_rem, rem_fix;
  logic [WIDTH-1:0] rem_mag;
  logic             step_qbit, dvd_neg, dvs_neg;

  div_nr_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .q_msb    (quot_q[WIDTH-1]),
    .divisor  (dvsr_q),
    .rem_next (step_rem),
    .q_bit    (step_qbit)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    dvsr_d    = dvsr_q;
    sgn_quo_d = sgn_quo_q;
    sgn_rem_d = sgn_rem_q;
    zflag_d   = zflag_q;
    q_d       = q_q;
    r_d       = r_q;
    dz_d      = dz_q;
    over_d    = 1'b0;
    dvd_neg   = bus.is_signed & bus.dividend[WIDTH-1];
    dvs_neg   = bus.is_signed & bus.divisor[WIDTH-1];
    rem_fix   = rem_q[WIDTH] ? rem_q + {1'b0, dvsr_q} : rem_q;
    rem_mag   = WIDTH'(rem_fix);

    case (state_q)
      IDLE: begin
        if (bus.start && !over_q) begin
          sgn_quo_d = dvd_neg ^ dvs_neg;
          sgn_rem_d = dvd_neg;
          rem_d     = '0;
          state_d   = RUN;
          // Divide-by-zero keeps the raw dividend so FIX can return it unmodified.
          if (bus.divisor == '0) begin
            zflag_d = 1'b1;
            quot_d  = bus.dividend;
            cnt_d   = CNT_LAST;
          end else begin
            zflag_d = 1'b0;
            quot_d  = WIDTH'(abs_mag(MAX_W'(bus.dividend), dvd_neg));
            dvsr_d  = WIDTH'(abs_mag(MAX_W'(bus.divisor), dvs_neg));
            cnt_d   = '0;
          end
        end
      end
      RUN: begin
        if (!zflag_q) begin
          rem_d  = step_rem;
          quot_d = {quot_q[WIDTH-2:0], step_qbit};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = FIX;
      end
      FIX: begin
        if (zflag_q) begin
          q_d = WIDTH'(DIV_ZERO_Q);
          r_d = quot_q;
        end else begin
          q_d = sgn_quo_q ? -quot_q : quot_q;
          r_d = sgn_rem_q ? -rem_mag : rem_mag;
        end
        dz_d    = zflag_q;
        over_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      dvsr_q    <= '0;
      sgn_quo_q <= 1'b0;
      sgn_rem_q <= 1'b0;
      zflag_q   <= 1'b0;
      q_q       <= '0;
      r_q       <= '0;
      dz_q      <= 1'b0;
      busy_q    <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      quot_q    <= quot_d;
      rem_q     <= rem_d;
      dvsr_q    <= dvsr_d;
      sgn_quo_q <= sgn_quo_d;
      sgn_rem_q <= sgn_rem_d;
      zflag_q   <= zflag_d;
      q_q       <= q_d;
      r_q       <= r_d;
      dz_q      <= dz_d;
      busy_q    <= busy_d;
      over_q    <= over_d;
    end
  end

  assign bus.q        = q_q;
  assign bus.r        = r_q;
  assign bus.div_zero = dz_q;
  assign bus.busy     = busy_q;
  assign bus.over     = over_q;
endmodule
